data_packer: RTL and testbench

DATA_PACKER -- requirements
Module: data_packer

---
 rtl/data_packer.sv | 232 +++++++++++++++++++++++
 tb/tb_data_packer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_packer.sv
// Frame serializer: header word followed by sign-extended samples, two bytes each, to a
// valid/ready byte sink. Samples are buffered in a small FIFO; dropped samples become zero words.
module data_packer #(
    parameter int          OW    = 14,
    parameter int          USBDW = 8,
    parameter int          NSAMP = 1024,
    parameter int          DEPTH = 16,
    parameter logic [15:0] HDR   = 16'hA55A
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [OW-1:0]    data_i,
    input  logic             valid_i,
    output logic [USBDW-1:0] wdata_o,
    output logic             wvalid_o,
    input  logic             wready_i,
    output logic             overflow_o,
    output logic             busy_o
);

    localparam int          AW = $clog2(DEPTH);
    localparam logic [15:0] NS = 16'(NSAMP);

    typedef enum logic [2:0] {S_IDLE, S_HDR0, S_HDR1, S_HI, S_LO} state_t;
    typedef enum logic [1:0] {K_NONE, K_ZHEAD, K_DATA, K_ZTAIL} kind_t;

    state_t            state_q, state_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              wvalid_q, wvalid_d;
    logic [7:0]        lo_q, lo_d;
    logic              ovf_q, ovf_d;
    logic [AW:0]       rd_q, rd_d, wr_q, wr_d;
    logic [15:0]       in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
    logic [15:0]       zdone_q, zdone_d, drop_q, drop_d;
    logic [OW+15:0]    mem_q [DEPTH];

    // Each FIFO entry carries the number of dropped samples that precede it (zpre).
    logic [AW:0]       cnt;
    logic              empty, full;
    logic [OW+15:0]    head, head2;
    logic [15:0]       head_zpre, head2_zpre;
    logic [15:0]       head_word, head2_word;
    kind_t             cur_kind, nxt_kind;
    logic [15:0]       cur_word, nxt_word;
    logic              xfer, take_start, in_win, acc, push, drop;
    logic              pop_data, consume_tail, consume_zhead;

    function automatic logic [15:0] sext(input logic [OW-1:0] d);
        return 16'($signed(d));
    endfunction

    assign cnt        = wr_q - rd_q;
    assign empty      = (cnt == '0);
    assign full       = (cnt == (AW+1)'(DEPTH));
    assign head       = mem_q[rd_q[AW-1:0]];
    assign head2      = mem_q[rd_q[AW-1:0] + AW'(1)];
    assign head_zpre  = head[OW+15:OW];
    assign head2_zpre = head2[OW+15:OW];
    assign head_word  = sext(head[OW-1:0]);
    assign head2_word = sext(head2[OW-1:0]);

    // Sample currently at the serializer, and the one that follows it once consumed.
    always_comb begin
        cur_kind = K_NONE;
        cur_word = '0;
        nxt_kind = K_NONE;
        nxt_word = '0;
        if (!empty) begin
            if (zdone_q < head_zpre) begin
                cur_kind = K_ZHEAD;
            end else begin
                cur_kind = K_DATA;
                cur_word = head_word;
            end
        end else if (drop_q != '0) begin
            cur_kind = K_ZTAIL;
        end
        case (cur_kind)
            K_ZHEAD: begin
                if (zdone_q + 16'd1 < head_zpre) begin
                    nxt_kind = K_ZHEAD;
                end else begin
                    nxt_kind = K_DATA;
                    nxt_word = head_word;
                end
            end
            K_DATA: begin
                if (cnt > (AW+1)'(1)) begin
                    if (head2_zpre != '0) begin
                        nxt_kind = K_ZHEAD;
                    end else begin
                        nxt_kind = K_DATA;
                        nxt_word = head2_word;
                    end
                end else if (drop_q != '0) begin
                    nxt_kind = K_ZTAIL;
                end
            end
            K_ZTAIL: begin
                if (drop_q > 16'd1) nxt_kind = K_ZTAIL;
            end
            default: nxt_kind = K_NONE;
        endcase
    end

    assign xfer          = wvalid_q & wready_i;
    assign take_start    = (state_q == S_IDLE) & start_i;
    assign in_win        = take_start | ((state_q != S_IDLE) & (in_cnt_q < NS));
    assign acc           = in_win & valid_i;
    assign pop_data      = (state_q == S_LO) & xfer & (cur_kind == K_DATA);
    assign consume_tail  = (state_q == S_LO) & xfer & (cur_kind == K_ZTAIL);
    assign consume_zhead = (state_q == S_LO) & xfer & (cur_kind == K_ZHEAD);
    assign push          = acc & (~full | pop_data);
    assign drop          = acc & ~push;

    always_comb begin
        wr_d      = wr_q + (AW+1)'(push);
        rd_d      = rd_q + (AW+1)'(pop_data);
        ovf_d     = ovf_q | drop;
        in_cnt_d  = take_start ? 16'(acc) : in_cnt_q + 16'(acc);
        out_cnt_d = out_cnt_q;
        zdone_d   = zdone_q;
        drop_d    = drop_q;
        if (take_start) begin
            out_cnt_d = '0;
            zdone_d   = '0;
            drop_d    = '0;
        end else begin
            if (pop_data)           zdone_d = '0;
            else if (consume_zhead) zdone_d = zdone_q + 16'd1;
            if (push)               drop_d = '0;
            else if (drop)          drop_d = drop_q + 16'd1;
            else if (consume_tail)  drop_d = drop_q - 16'd1;
            if ((state_q == S_LO) && xfer) out_cnt_d = out_cnt_q + 16'd1;
        end
    end

    always_comb begin
        state_d  = state_q;
        wvalid_d = wvalid_q;
        wdata_d  = wdata_q;
        lo_d     = lo_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d  = S_HDR0;
                    wvalid_d = 1'b1;
                    wdata_d  = HDR[15:8];
                end
            end
            S_HDR0: begin
                if (xfer) begin
                    state_d = S_HDR1;
                    wdata_d = HDR[7:0];
                end
            end
            S_HDR1: begin
                if (xfer) begin
                    state_d  = S_HI;
                    wvalid_d = (cur_kind != K_NONE);
                    wdata_d  = cur_word[15:8];
                    lo_d     = cur_word[7:0];
                end
            end
            S_HI: begin
                if (xfer) begin
                    state_d = S_LO;
                    wdata_d = lo_q;
                end else if (!wvalid_q && cur_kind != K_NONE) begin
                    wvalid_d = 1'b1;
                    wdata_d  = cur_word[15:8];
                    lo_d     = cur_word[7:0];
                end
            end
            S_LO: begin
                if (xfer) begin
                    if (out_cnt_q < NS - 16'd1) begin
                        state_d  = S_HI;
                        wvalid_d = (nxt_kind != K_NONE);
                        wdata_d  = nxt_word[15:8];
                        lo_d     = nxt_word[7:0];
                    end else begin
                        state_d  = S_IDLE;
                        wvalid_d = 1'b0;
                        wdata_d  = '0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            wvalid_q  <= 1'b0;
            wdata_q   <= '0;
            lo_q      <= '0;
            ovf_q     <= 1'b0;
            rd_q      <= '0;
            wr_q      <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            zdone_q   <= '0;
            drop_q    <= '0;
        end else begin
            state_q   <= state_d;
            wvalid_q  <= wvalid_d;
            wdata_q   <= wdata_d;
            lo_q      <= lo_d;
            ovf_q     <= ovf_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            zdone_q   <= zdone_d;
            drop_q    <= drop_d;
        end
    end

    // Pushed entry absorbs any drops queued behind the previous entry.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_q[AW-1:0]] <= {drop_q - 16'(consume_tail), data_i};
    end

    assign wdata_o    = wdata_q;
    assign wvalid_o   = wvalid_q;
    assign overflow_o = ovf_q;
    assign busy_o     = (state_q != S_IDLE);

endmodule

// File: tb/tb_data_packer.sv
// Bench for data_packer: two instances (DEPTH 4 and 2) against a queue-based byte model,
// plus literal frame expectations.
module tb_data_packer;
    localparam int OW = 14;
    localparam int NS = 4;
    localparam int DEPTHS [2] = '{4, 2};

    logic          clk = 1'b0;
    logic          rst, start, valid, wready;
    logic [OW-1:0] data;
    logic [7:0]    wdata [2];
    logic          wvalid [2];
    logic          ovf [2];
    logic          busy [2];

    always #5 clk = ~clk;

    data_packer #(.OW(OW), .USBDW(8), .NSAMP(NS), .DEPTH(4), .HDR(16'hA55A)) u0 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .data_i(data), .valid_i(valid),
        .wdata_o(wdata[0]), .wvalid_o(wvalid[0]), .wready_i(wready),
        .overflow_o(ovf[0]), .busy_o(busy[0]));

    data_packer #(.OW(OW), .USBDW(8), .NSAMP(NS), .DEPTH(2), .HDR(16'hA55A)) u1 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .data_i(data), .valid_i(valid),
        .wdata_o(wdata[1]), .wvalid_o(wvalid[1]), .wready_i(wready),
        .overflow_o(ovf[1]), .busy_o(busy[1]));

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s[u%0d]: got %0h expected %0h at %0t", nm, k, act, exp, $time);
    endtask

    // Model: expected byte stream per instance; bit 8 marks the low byte of a buffered sample.
    logic [8:0] expq [2][$];
    logic [7:0] rec  [2][$];
    logic [7:0] lit_q [$];
    logic [OW-1:0] samp_q [$];
    bit         m_busy [2], m_ovf [2], stall_prev [2], exp_valid [2];
    logic [7:0] prev_data [2];
    int         occ [2], in_cnt [2], left [2];

    function automatic logic [15:0] sx(input logic [OW-1:0] d);
        int v;
        v = int'(d);
        if (v >= (1 << (OW-1))) v -= (1 << OW);
        return v[15:0];
    endfunction

    logic       xf, pop_real, busy_pre, take;
    logic [8:0] e;
    logic [15:0] w;

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                chk("rst_wvalid", k, wvalid[k], 0);
                chk("rst_wdata", k, wdata[k], 0);
                chk("rst_busy", k, busy[k], 0);
                chk("rst_ovf", k, ovf[k], 0);
                expq[k].delete();
                m_busy[k] = 0; m_ovf[k] = 0; stall_prev[k] = 0; exp_valid[k] = 0;
                occ[k] = 0; in_cnt[k] = 0; left[k] = 0;
            end else begin
                chk("busy", k, busy[k], m_busy[k]);
                chk("overflow", k, ovf[k], m_ovf[k]);
                if (stall_prev[k]) begin
                    chk("stall_valid", k, wvalid[k], 1);
                    chk("stall_data", k, wdata[k], prev_data[k]);
                end
                if (exp_valid[k]) chk("no_bubble", k, wvalid[k], 1);
                if (wvalid[k]) begin
                    chk("byte_expected", k, expq[k].size() > 0, 1);
                    if (expq[k].size() > 0) chk("byte", k, wdata[k], expq[k][0][7:0]);
                end
                busy_pre = m_busy[k];
                pop_real = 0;
                xf = wvalid[k] && wready;
                if (xf && expq[k].size() > 0) begin
                    e = expq[k].pop_front();
                    pop_real = e[8];
                    rec[k].push_back(wdata[k]);
                    left[k]--;
                    if (left[k] == 0) m_busy[k] = 0;
                end
                stall_prev[k] = wvalid[k] && !wready;
                prev_data[k]  = wdata[k];
                exp_valid[k]  = expq[k].size() > 0;
                take = start && !busy_pre;
                if (take) begin
                    expq[k].push_back({1'b0, 8'hA5});
                    expq[k].push_back({1'b0, 8'h5A});
                    m_busy[k] = 1; left[k] = 2 + 2*NS; in_cnt[k] = 0; exp_valid[k] = 1;
                end
                if (valid && (take || (busy_pre && in_cnt[k] < NS))) begin
                    in_cnt[k]++;
                    if (occ[k] < DEPTHS[k] || pop_real) begin
                        w = sx(data);
                        expq[k].push_back({1'b0, w[15:8]});
                        expq[k].push_back({1'b1, w[7:0]});
                        occ[k]++;
                    end else begin
                        m_ovf[k] = 1;
                        expq[k].push_back(9'h000);
                        expq[k].push_back(9'h000);
                    end
                end
                if (pop_real) occ[k]--;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1; start = 0; valid = 0;
        tick(); tick();
        rst = 0;
        rec[0].delete(); rec[1].delete();
    endtask

    task automatic send_samples();
        foreach (samp_q[i]) begin
            data = samp_q[i]; valid = 1;
            tick();
        end
        valid = 0;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while ((busy[0] || busy[1]) && n < 300) begin
            tick();
            n++;
        end
        chk(nm, 0, busy[0] | busy[1], 0);
    endtask

    task automatic check_rec(input int k, input string nm);
        chk({nm, "_len"}, k, rec[k].size(), lit_q.size());
        for (int i = 0; i < lit_q.size() && i < rec[k].size(); i++)
            chk(nm, k, rec[k][i], lit_q[i]);
    endtask

    initial begin
        int n;
        rst = 1; start = 0; valid = 0; wready = 0; data = '0;
        do_reset();

        // basic frame; DEPTH=2 instance drops sample 2 under this flow
        wready = 1;
        samp_q = '{14'h0001, 14'h3FFF, 14'h2000, 14'h0123};
        start = 1;
        @(posedge clk); #1;
        chk("hdr_latency", 0, wvalid[0], 1);
        chk("hdr_byte", 0, wdata[0], 8'hA5);
        #1 start = 0;
        send_samples();
        wait_idle("t1_idle");
        lit_q = '{8'hA5, 8'h5A, 8'h00, 8'h01, 8'hFF, 8'hFF, 8'hE0, 8'h00, 8'h01, 8'h23};
        check_rec(0, "t1_bytes");
        lit_q = '{8'hA5, 8'h5A, 8'h00, 8'h01, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h01, 8'h23};
        check_rec(1, "t1_bytes");
        chk("t1_ovf", 0, ovf[0], 0);
        chk("t1_ovf", 1, ovf[1], 1);

        // backpressure: wready toggling
        do_reset();
        wready = 0; start = 1;
        tick();
        start = 0;
        for (int c = 0; c < 80; c++) begin
            wready = c[0];
            if (c < 4) begin valid = 1; data = samp_q[c]; end
            else valid = 0;
            tick();
            if (c > 4 && !busy[0] && !busy[1]) break;
        end
        wready = 1;
        wait_idle("t2_idle");
        lit_q = '{8'hA5, 8'h5A, 8'h00, 8'h01, 8'hFF, 8'hFF, 8'hE0, 8'h00, 8'h01, 8'h23};
        check_rec(0, "t2_bytes");

        // overflow with the sink stalled
        do_reset();
        wready = 0; start = 1;
        tick();
        start = 0;
        samp_q = '{14'h0011, 14'h0022, 14'h0033, 14'h0044, 14'h0055, 14'h0066};
        send_samples();
        repeat (3) tick();
        chk("t3_ovf", 0, ovf[0], 0);
        chk("t3_ovf", 1, ovf[1], 1);
        chk("t3_hold_valid", 0, wvalid[0], 1);
        chk("t3_hold_byte", 0, wdata[0], 8'hA5);
        wready = 1;
        wait_idle("t3_idle");
        lit_q = '{8'hA5, 8'h5A, 8'h00, 8'h11, 8'h00, 8'h22, 8'h00, 8'h33, 8'h00, 8'h44};
        check_rec(0, "t3_bytes");
        lit_q = '{8'hA5, 8'h5A, 8'h00, 8'h11, 8'h00, 8'h22, 8'h00, 8'h00, 8'h00, 8'h00};
        check_rec(1, "t3_bytes");

        // gating: idle samples, mid-frame start, start held across frame end
        do_reset();
        wready = 1; data = 14'h00AA; valid = 1;
        repeat (3) tick();
        valid = 0;
        tick();
        chk("t4_idle_valid", 0, wvalid[0], 0);
        chk("t4_idle_busy", 0, busy[0], 0);
        start = 1;
        tick();
        start = 0;
        samp_q = '{14'h0005, 14'h3FFE, 14'h1234, 14'h0777};
        foreach (samp_q[i]) begin
            data = samp_q[i]; valid = 1; start = (i == 1);
            tick();
        end
        valid = 0; start = 1;
        n = 0;
        while (busy[0] && n < 100) begin tick(); n++; end
        start = 0;
        repeat (3) tick();
        chk("t4_no_restart", 0, busy[0], 0);
        valid = 1; repeat (2) tick(); valid = 0;
        tick();
        chk("t4_late_valid", 0, wvalid[0], 0);
        lit_q = '{8'hA5, 8'h5A, 8'h00, 8'h05, 8'hFF, 8'hFE, 8'h12, 8'h34, 8'h07, 8'h77};
        check_rec(0, "t4_bytes");

        // reset mid-frame, then a clean frame
        do_reset();
        wready = 1; start = 1;
        tick();
        start = 0;
        samp_q = '{14'h0001, 14'h3FFF, 14'h2000, 14'h0123};
        send_samples();
        n = 0;
        while (rec[0].size() < 5 && n < 50) begin tick(); n++; end
        chk("t5_reach_byte5", 0, rec[0].size(), 5);
        rst = 1;
        #1;
        chk("t5_abort_valid", 0, wvalid[0], 0);
        chk("t5_abort_valid", 1, wvalid[1], 0);
        chk("t5_abort_busy", 0, busy[0], 0);
        tick();
        rst = 0; start = 1;
        rec[0].delete(); rec[1].delete();
        @(posedge clk); #1;
        chk("t5_first_start", 0, wdata[0], 8'hA5);
        #1 start = 0;
        send_samples();
        wait_idle("t5_idle");
        lit_q = '{8'hA5, 8'h5A, 8'h00, 8'h01, 8'hFF, 8'hFF, 8'hE0, 8'h00, 8'h01, 8'h23};
        check_rec(0, "t5_bytes");

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
